// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;

    // Default widths
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned WDATA_W = 8;
    localparam int unsigned RDATA_W = 16;

    // Requester indices
    localparam int unsigned PORT_CPU = 0;
    localparam int unsigned PORT_LDR = 1;

    // Arbiter FSM
    typedef enum logic {
        ST_IDLE,
        ST_RD_WAIT
    } state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signals of the data-memory arbiter.
interface dmem_arbiter_if
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W  = dmem_pkg::ADDR_W,
    parameter int unsigned WDATA_W = dmem_pkg::WDATA_W,
    parameter int unsigned RDATA_W = dmem_pkg::RDATA_W
) ();

    // Port 0 (CPU load/store unit)
    logic               p0_req;
    logic               p0_we;
    logic               p0_lock;
    logic [ADDR_W-1:0]  p0_addr;
    logic [WDATA_W-1:0] p0_wdata;
    logic               p0_gnt;
    logic               p0_rvalid;

    // Port 1 (loader / debug)
    logic               p1_req;
    logic               p1_we;
    logic               p1_lock;
    logic [ADDR_W-1:0]  p1_addr;
    logic [WDATA_W-1:0] p1_wdata;
    logic               p1_gnt;
    logic               p1_rvalid;

    // Shared read return
    logic [RDATA_W-1:0] rdata;

    // Memory side
    logic [ADDR_W-1:0]  mem_addr;
    logic [WDATA_W-1:0] mem_wdata;
    logic               mem_we;
    logic               mem_read_e;
    logic [RDATA_W-1:0] mem_rdata;

    // Arbiter view
    modport slave (
        input  p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
        output p0_gnt, p0_rvalid,
        input  p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
        output p1_gnt, p1_rvalid,
        output rdata,
        output mem_addr, mem_wdata, mem_we, mem_read_e,
        input  mem_rdata
    );

    // Requester / memory view
    modport master (
        output p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
        input  p0_gnt, p0_rvalid,
        output p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
        input  p1_gnt, p1_rvalid,
        input  rdata,
        input  mem_addr, mem_wdata, mem_we, mem_read_e,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker: masked requests in, one-hot grant out.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    input  logic [1:0] mask,
    output logic [1:0] gnt
);

    logic [1:0] act;

    // Single eligible requester wins outright; on conflict prio decides
    always_comb begin
        act = req & mask;
        gnt = act;
        if (&act) begin
            gnt = '0;
            if (prio) gnt[PORT_LDR] = 1'b1;
            else      gnt[PORT_CPU] = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU and the loader port.
// Combinational grant in IDLE, one-cycle read return, optional lock.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W  = dmem_pkg::ADDR_W,
    parameter int unsigned WDATA_W = dmem_pkg::WDATA_W,
    parameter int unsigned RDATA_W = dmem_pkg::RDATA_W
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);

    state_e state_q, state_d;
    logic   prio_q, prio_d;
    logic   lock_q, lock_d;
    logic   lock_own_q, lock_own_d;
    logic   rd_own_q, rd_own_d;

    logic [1:0]         req;
    logic [1:0]         mask;
    logic [1:0]         gnt;
    logic               any_gnt;
    logic               win;
    logic               win_we;
    logic               win_lock;
    logic [ADDR_W-1:0]  win_addr;
    logic [WDATA_W-1:0] win_wdata;
    logic               rd_phase;
    logic [RDATA_W-1:0] rdata_sel;

    assign req = {bus.p1_req, bus.p0_req};

    // Eligibility: nothing outside IDLE or during reset; only the owner while locked
    always_comb begin
        mask = 2'b11;
        if (lock_q) begin
            mask = '0;
            mask[lock_own_q] = 1'b1;
        end
        if (state_q != ST_IDLE || rst) mask = '0;
    end

    rr_arb2 u_rr_arb2 (
        .req  (req),
        .prio (prio_q),
        .mask (mask),
        .gnt  (gnt)
    );

    // Winner selection and memory strobes
    always_comb begin
        any_gnt   = |gnt;
        win       = gnt[PORT_LDR];
        win_we    = win ? bus.p1_we    : bus.p0_we;
        win_lock  = win ? bus.p1_lock  : bus.p0_lock;
        win_addr  = win ? bus.p1_addr  : bus.p0_addr;
        win_wdata = win ? bus.p1_wdata : bus.p0_wdata;

        bus.p0_gnt     = gnt[PORT_CPU];
        bus.p1_gnt     = gnt[PORT_LDR];
        bus.mem_we     = any_gnt &  win_we;
        bus.mem_read_e = any_gnt & ~win_we;
        bus.mem_addr   = any_gnt ? win_addr  : '0;
        bus.mem_wdata  = any_gnt ? win_wdata : '0;
    end

    // Read return: driven from registered state, suppressed while in reset
    always_comb begin
        rd_phase      = (state_q == ST_RD_WAIT) && !rst;
        rdata_sel     = rd_phase ? bus.mem_rdata : '0;
        bus.rdata     = rdata_sel;
        bus.p0_rvalid = rd_phase && (rd_own_q == 1'(PORT_CPU));
        bus.p1_rvalid = rd_phase && (rd_own_q == 1'(PORT_LDR));
    end

    // Next state: FSM, fairness pointer and lock tracking
    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        lock_d     = lock_q;
        lock_own_d = lock_own_q;
        rd_own_d   = rd_own_q;
        case (state_q)
            ST_IDLE: begin
                if (any_gnt) begin
                    if (!win_we) begin
                        state_d  = ST_RD_WAIT;
                        rd_own_d = win;
                    end
                    if (win_lock) begin
                        lock_d     = 1'b1;
                        lock_own_d = win;
                    end else begin
                        // covers both a plain grant and an owner's unlocking access
                        lock_d = 1'b0;
                        prio_d = ~win;
                    end
                end else if (lock_q && !req[lock_own_q]) begin
                    lock_d = 1'b0;
                    prio_d = ~lock_own_q;
                end
            end
            ST_RD_WAIT: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            prio_q     <= 1'b0;
            lock_q     <= 1'b0;
            lock_own_q <= 1'b0;
            rd_own_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            lock_q     <= lock_d;
            lock_own_q <= lock_own_d;
            rd_own_q   <= rd_own_d;
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 = CPU load/store unit, port 1 = loader/debug port.
- Round-robin arbitration with an optional lock, so a requester can issue back-to-back accesses atomically (e.g. two byte writes for a 16-bit store).
- Drives the memory's address, write data, write-enable and read-enable.
- Returns registered read data one cycle after issue.

Parameters:
- ADDR_W, 16, address width of requesters and memory.
- WDATA_W, 8, write data width (memory write port).
- RDATA_W, 16, read data width (memory read port).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- p0_req  input  1  port 0 access request.
- p0_we  input  1  port 0: 1 = write, 0 = read.
- p0_lock  input  1  port 0: keep ownership after this access.
- p0_addr  input  ADDR_W  port 0 address.
- p0_wdata  input  WDATA_W  port 0 write data.
- p0_gnt  output  1  port 0 request accepted this cycle.
- p0_rvalid  output  1  port 0 read data valid.
- p1_req, p1_we, p1_lock, p1_addr, p1_wdata, p1_gnt, p1_rvalid: same as port 0, for port 1.
- rdata  output  RDATA_W  read data, shared by both ports; qualified by pX_rvalid.
- mem_addr  output  ADDR_W  to memory address.
- mem_wdata  output  WDATA_W  to memory write data.
- mem_we  output  1  to memory write enable.
- mem_read_e  output  1  to memory read enable.
- mem_rdata  input  RDATA_W  from memory registered read data.

Behaviour:
- FSM states:
  - IDLE: can grant.
  - RD_WAIT: read in flight; no grant.
- Grant is combinational in IDLE:
  - With one requester, that port wins.
  - With both requesting, the port indicated by prio wins.
  - prio is a 1-bit register: the port favoured on the next conflict.
- On a grant, the same cycle:
  - pX_gnt=1.
  - mem_addr and mem_wdata come from the winner.
  - Winner's we=1 gives mem_we=1. Winner's we=0 gives mem_read_e=1.
  - mem_we and mem_read_e are never both 1.
- Write grant: completes in the grant cycle; FSM stays IDLE; a back-to-back grant is possible next cycle.
- Read grant:
  - FSM goes to RD_WAIT.
  - In RD_WAIT: pX_rvalid=1 for the owner only; rdata = mem_rdata; both gnt=0.
  - FSM returns to IDLE next cycle.
  - Read latency: gnt at cycle N, rvalid at N+1.
  - Max read throughput is one read per 2 cycles.
- prio update on every grant without lock: prio becomes the non-winning port.
- Lock:
  - Granted with lock=1: the lock owner is recorded, prio is unchanged, and the next IDLE grant goes to the owner only. The other port is masked even if the owner is idle.
  - Lock releases when the owner is granted with lock=0, or when the owner's req=0 for a full IDLE cycle.
  - On release, prio = other port.
- Outputs during no grant: mem_we=0, mem_read_e=0, mem_addr=0, mem_wdata=0.
- A request not granted must be held stable by the requester until gnt. The arbiter keeps no request queue.
- Reset (synchronous, any state, including mid-read RD_WAIT):
  - FSM=IDLE, prio=0, lock cleared.
  - While rst=1: all gnt, rvalid, mem_we and mem_read_e are 0.
  - An in-flight read is dropped; no rvalid after reset.
- Simultaneous events:
  - A request arriving in RD_WAIT waits; it is granted the next IDLE cycle.
  - A lock owner dropping req while the other port requests: release is seen that cycle, and the other port is granted in the following cycle.

Decomposition:
- Shared package dmem_pkg:
  - FSM state enum (ST_IDLE, ST_RD_WAIT).
  - Port index constants PORT_CPU=0, PORT_LDR=1.
  - Default widths ADDR_W, WDATA_W, RDATA_W.
- One natural sub-module: rr_arb2, a 2-way round-robin picker (req[1:0], prio, mask → onehot gnt). Everything else stays in dmem_arbiter.

Test Plan:
- Single read: p0 read addr 0x0010, memory holds 0x00AB → p0_gnt cycle N with mem_read_e=1, mem_addr=0x0010; p0_rvalid=1, rdata=0x00AB at N+1; p1_rvalid=0.
- Conflict fairness: p0 and p1 both write continuously, prio=0 after reset → grants alternate p0,p1,p0,p1 on consecutive cycles; writes land at the correct addresses.
- Lock: p1 writes 0x0100 (lock=1) then 0x0101 (lock=0) while p0 requests → both p1 writes granted consecutively, then p0 granted; mem shows bytes at 0x0100/0x0101.
- Lock release by drop: p0 locks, then deasserts req for one cycle while p1 requests → p1 granted one cycle after the drop.
- Read/request overlap: p0 read granted at N, p1 write requested at N → p1_gnt=0 at N+1 (RD_WAIT), p1_gnt=1 at N+2.
- Reset mid-read: p1 read granted, rst=1 next cycle → p1_rvalid=0, mem strobes 0; after rst low, p0 wins the first conflict (prio=0).
